// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic tile controller.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } tile_ctrl_state_t;

  localparam int DEF_N1 = 4;
  localparam int DEF_N2 = 4;
  localparam int DIAG   = DEF_N1 + DEF_N2 - 1;

endpackage

// File: rtl/systolic_tile_ctrl_wave_delay.sv
// Shift register carrying {init pulse, drop flag} down the array diagonals.
// Each tap is one cycle later than the previous one.
module wave_delay #(
  parameter int DEPTH = 7,
  parameter int W     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            din,
  output logic [DEPTH-1:0][W-1:0] taps
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Sequences an output-stationary systolic array through back-to-back reduction tiles,
// generating operand read addresses, the diagonal init wave and a trailing flush tile.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter int N1      = DEF_N1,
  parameter int N2      = DEF_N2,
  parameter int K_W     = 16,
  parameter int TILE_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [K_W-1:0]      k_len,
  input  logic [TILE_W-1:0]   num_tiles,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                feed_zero,
  output logic [N1+N2-2:0]    init_diag,
  output logic [N1+N2-2:0]    drop_diag
);

  localparam int DIAG_N    = N1 + N2 - 1;
  localparam int DEPTH     = MEM_LAT + DIAG_N - 1;
  // Flush wave reaches the last diagonal, then the bottom-right results need N2 more cycles.
  localparam int DRAIN_LEN = MEM_LAT + DIAG_N - 1 + N2;
  localparam int CNT_W     = $clog2(DRAIN_LEN + 1);

  localparam logic [K_W-1:0]    K_ONE    = 1;
  localparam logic [TILE_W-1:0] TILE_ONE = 1;

  tile_ctrl_state_t state_q, state_d;

  logic [K_W-1:0]    k_len_q, k_cnt;
  logic [TILE_W-1:0] tiles_q, tile_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  drain_cnt;
  logic              zero_done;

  logic              start_ok, zero_job, last_k, last_beat, last_drain;
  logic              pulse, drop;
  logic [DEPTH-1:0][1:0] taps;

  // A zero-length job still owns its done cycle, so a start there is ignored.
  assign start_ok   = start && !zero_done;
  assign zero_job   = (k_len == '0) || (num_tiles == '0);
  assign last_k     = (k_cnt == k_len_q - K_ONE);
  assign last_beat  = last_k && (tile_cnt == tiles_q - TILE_ONE);
  assign last_drain = (drain_cnt == CNT_W'(DRAIN_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok && !zero_job) state_d = FEED;
      FEED:    if (last_beat) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (last_drain) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_q   <= '0;
      tiles_q   <= '0;
      k_cnt     <= '0;
      tile_cnt  <= '0;
      addr_q    <= '0;
      drain_cnt <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= (state_q == IDLE) && start_ok && zero_job;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            k_len_q   <= k_len;
            tiles_q   <= num_tiles;
            k_cnt     <= '0;
            tile_cnt  <= '0;
            addr_q    <= '0;
            drain_cnt <= '0;
          end
        end
        FEED: begin
          addr_q <= addr_q + 1'b1;
          if (last_k) begin
            k_cnt    <= '0;
            tile_cnt <= tile_cnt + TILE_ONE;
          end else begin
            k_cnt <= k_cnt + K_ONE;
          end
        end
        FLUSH:   drain_cnt <= '0;
        DRAIN:   drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = zero_done || ((state_q == DRAIN) && last_drain);
  assign rd_en     = (state_q == FEED);
  assign rd_addr   = addr_q;
  assign feed_zero = (state_q == FLUSH);
  assign pulse     = ((state_q == FEED) && (k_cnt == '0)) || (state_q == FLUSH);
  assign drop      = (state_q == FEED) && (k_cnt == '0) && (tile_cnt == '0);

  wave_delay #(
    .DEPTH (DEPTH),
    .W     (2)
  ) u_wave (
    .clk  (clk),
    .rst  (rst),
    .din  ({pulse, drop}),
    .taps (taps)
  );

  always_comb begin
    init_diag = '0;
    drop_diag = '0;
    for (int d = 0; d < DIAG_N; d++) begin
      init_diag[d] = taps[MEM_LAT - 1 + d][1];
      drop_diag[d] = taps[MEM_LAT - 1 + d][0];
    end
  end

endmodule
